frv_timer_bank: RTL

Multi-channel successor to the core's single mtime/mtimecmp timer.
- One shared 64-bit mtime with a programmable prescaler.
- NCH independent compare channels, each one-shot or periodic with auto-reload.
- Sticky, write-1-to-clear (W1C) pending bits.
- Sits on the core MMIO bus; drives the machine timer interrupt plus a per-channel interrupt vector.

---
 rtl/frv_timer_bank.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/frv_timer_bank.sv
// Multi-channel machine timer: one shared prescaled 64-bit mtime feeding NCH
// compare channels (one-shot or periodic) with sticky W1C pending bits on MMIO.

module frv_timer_chan #(
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic [63:0] mtime,
    input  logic [31:0] wdata,
    input  logic        cmp_lo_we,
    input  logic        cmp_hi_we,
    input  logic        ctrl_we,
    input  logic        period_we,
    input  logic        w1c,
    output logic [63:0] cmp,
    output logic [31:0] period,
    output logic        en,
    output logic        periodic,
    output logic        pending
);
    logic match;
    assign match = en && (mtime >= cmp);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            cmp      <= CMP_RESET;
            period   <= '0;
            en       <= 1'b0;
            periodic <= 1'b0;
            pending  <= 1'b0;
        end else begin
            // software writes take priority over the hardware reload / one-shot clear
            if (cmp_lo_we)
                cmp[31:0] <= wdata;
            else if (cmp_hi_we)
                cmp[63:32] <= wdata;
            else if (match && periodic)
                cmp <= cmp + {32'b0, period};

            if (ctrl_we)
                {periodic, en} <= wdata[1:0];
            else if (match && !periodic)
                en <= 1'b0;

            if (period_we)
                period <= wdata;

            pending <= match | (pending & ~w1c);
        end
    end
endmodule

module frv_timer_bank #(
    parameter int          NCH            = 4,
    parameter int          PRESCALE_W     = 8,
    parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000,
    parameter logic [63:0] CMP_RESET      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic           g_clk,
    input  logic           g_reset,
    input  logic           inhibit_tm,
    output logic [63:0]    mtime,
    output logic           timer_interrupt,
    output logic [NCH-1:0] irq_vec,
    input  logic           mmio_en,
    input  logic           mmio_wen,
    input  logic [31:0]    mmio_addr,
    input  logic [31:0]    mmio_wdata,
    output logic [31:0]    mmio_rdata,
    output logic           mmio_error
);
    localparam logic [31:0] CH_END = 32'h10 + 32'(NCH) * 32'h10;

    logic [63:0]           mtime_q;
    logic [PRESCALE_W-1:0] prescale_q, count_q;
    logic [31:0]           off, rd;
    logic [27:0]           ch_idx;
    logic [1:0]            fld;
    logic                  hit, err, acc_wr, tick;
    logic                  wr_lo, wr_hi, wr_pre, wr_stat;

    logic [NCH-1:0][63:0]  cmp;
    logic [NCH-1:0][31:0]  period;
    logic [NCH-1:0]        en, periodic, pending, w1c;
    logic [NCH-1:0]        cmp_lo_we, cmp_hi_we, ctrl_we, period_we;

    assign off     = mmio_addr & ~MMIO_BASE_MASK;
    assign hit     = (mmio_addr & MMIO_BASE_MASK) == (MMIO_BASE_ADDR & MMIO_BASE_MASK);
    assign err     = !hit || (off[1:0] != 2'b00) || (off >= CH_END);
    assign acc_wr  = mmio_en && mmio_wen && !err;
    assign fld     = off[3:2];
    assign ch_idx  = off[31:4] - 28'h1;

    assign wr_lo   = acc_wr && (off == 32'h0);
    assign wr_hi   = acc_wr && (off == 32'h4);
    assign wr_pre  = acc_wr && (off == 32'h8);
    assign wr_stat = acc_wr && (off == 32'hC);
    assign w1c     = wr_stat ? mmio_wdata[NCH-1:0] : '0;

    assign tick    = !inhibit_tm && (count_q == prescale_q);

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            logic sel;
            assign sel          = acc_wr && (off >= 32'h10) && (ch_idx == 28'(k));
            assign cmp_lo_we[k] = sel && (fld == 2'd0);
            assign cmp_hi_we[k] = sel && (fld == 2'd1);
            assign ctrl_we[k]   = sel && (fld == 2'd2);
            assign period_we[k] = sel && (fld == 2'd3);

            frv_timer_chan #(.CMP_RESET(CMP_RESET)) u_chan (
                .g_clk     (g_clk),
                .g_reset   (g_reset),
                .mtime     (mtime_q),
                .wdata     (mmio_wdata),
                .cmp_lo_we (cmp_lo_we[k]),
                .cmp_hi_we (cmp_hi_we[k]),
                .ctrl_we   (ctrl_we[k]),
                .period_we (period_we[k]),
                .w1c       (w1c[k]),
                .cmp       (cmp[k]),
                .period    (period[k]),
                .en        (en[k]),
                .periodic  (periodic[k]),
                .pending   (pending[k])
            );
        end
    endgenerate

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            mtime_q    <= '0;
            count_q    <= '0;
            prescale_q <= '0;
        end else begin
            if (wr_pre) begin
                prescale_q <= mmio_wdata[PRESCALE_W-1:0];
                count_q    <= '0;
            end else if (!inhibit_tm) begin
                count_q <= (count_q == prescale_q) ? '0 : count_q + 1'b1;
            end

            // a half write holds the other half rather than letting it tick
            if (wr_lo)
                mtime_q[31:0] <= mmio_wdata;
            else if (wr_hi)
                mtime_q[63:32] <= mmio_wdata;
            else if (tick)
                mtime_q <= mtime_q + 64'd1;
        end
    end

    always_comb begin
        rd = '0;
        if (off < 32'h10) begin
            case (fld)
                2'd0: rd = mtime_q[31:0];
                2'd1: rd = mtime_q[63:32];
                2'd2: rd[PRESCALE_W-1:0] = prescale_q;
                default: rd[NCH-1:0] = pending;
            endcase
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_idx == 28'(i)) begin
                    case (fld)
                        2'd0: rd = cmp[i][31:0];
                        2'd1: rd = cmp[i][63:32];
                        2'd2: rd[1:0] = {periodic[i], en[i]};
                        default: rd = period[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            mmio_rdata <= '0;
            mmio_error <= 1'b0;
        end else if (mmio_en) begin
            mmio_rdata <= err ? 32'h0 : rd;
            mmio_error <= err;
        end
    end

    assign mtime           = mtime_q;
    assign irq_vec         = pending;
    assign timer_interrupt = |pending;
endmodule
